// File: rtl/list_sum_ctrl.sv
// Control FSM for a linked-list summation datapath (SUM/NEXT registers, memory).
// Walks nodes value/link pairs from address 0, stopping on a zero link or the node limit.
module list_sum_ctrl #(
  parameter int MAX_NODES = 8,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             NEXT_ZERO,
  output logic             SUM_SEL,
  output logic             NEXT_SEL,
  output logic             A_SEL,
  output logic             LD_SUM,
  output logic             LD_NEXT,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] node_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ADD  = 3'd2,
    LINK = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_NODES);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The ADD increment still lands on an abort cycle, since the datapath loads SUM that cycle too.
  always_ff @(posedge clk) begin
    if (rst) begin
      node_count <= {CNT_W{1'b0}};
    end else begin
      case (state)
        INIT:    node_count <= {CNT_W{1'b0}};
        ADD:     node_count <= (node_count == CNT_SAT) ? node_count
                                                       : node_count + {{(CNT_W-1){1'b0}}, 1'b1};
        default: node_count <= node_count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    SUM_SEL    = 1'b0;
    NEXT_SEL   = 1'b0;
    A_SEL      = 1'b0;
    LD_SUM     = 1'b0;
    LD_NEXT    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = INIT;
        end else begin
          state_next = IDLE;
        end
      end
      INIT: begin
        LD_SUM  = 1'b1;
        LD_NEXT = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          state_next = ADD;
        end
      end
      ADD: begin
        SUM_SEL = 1'b1;
        LD_SUM  = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          state_next = LINK;
        end
      end
      LINK: begin
        A_SEL    = 1'b1;
        NEXT_SEL = 1'b1;
        LD_NEXT  = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (NEXT_ZERO) begin
          state_next = DONE;
        end else if (node_count >= CNT_LIMIT) begin
          state_next = ERR;
        end else begin
          state_next = ADD;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        err        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_list_sum_ctrl.sv
// Bench for list_sum_ctrl: wraps the FSM with a memory/SUM/NEXT datapath and
// checks completion pulses against a list-walking reference through a scoreboard.
module tb_list_sum_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, NEXT_ZERO;
  logic       SUM_SEL, NEXT_SEL, A_SEL, LD_SUM, LD_NEXT, busy, done, err;
  logic [4:0] node_count;

  list_sum_ctrl #(.MAX_NODES(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .NEXT_ZERO(NEXT_ZERO),
    .SUM_SEL(SUM_SEL), .NEXT_SEL(NEXT_SEL), .A_SEL(A_SEL), .LD_SUM(LD_SUM),
    .LD_NEXT(LD_NEXT), .busy(busy), .done(done), .err(err), .node_count(node_count)
  );

  always #5 clk = ~clk;

  // Datapath environment driven by the controller
  logic [7:0]  mem [256];
  logic [7:0]  next_r;
  logic [15:0] sum_r;
  logic [7:0]  addr, mem_q, next_in;
  assign addr      = A_SEL ? next_r + 8'd1 : next_r;
  assign mem_q     = mem[addr];
  assign next_in   = NEXT_SEL ? mem_q : 8'd0;
  assign NEXT_ZERO = (next_in == 8'd0);

  always @(posedge clk) begin
    if (LD_SUM)  sum_r  <= SUM_SEL ? sum_r + {8'd0, mem_q} : 16'd0;
    if (LD_NEXT) next_r <= next_in;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int cyc;
    int sum;
    int cnt;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0d err=%0d with no traversal outstanding (cycle %0d)",
                 done, err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("kind_err", int'(err), int'(e.is_err));
        check("kind_done", int'(done), int'(!e.is_err));
        check("pulse_cycle", cyc, e.cyc);
        check("sum", int'(sum_r), e.sum);
        check("node_count", int'(node_count), e.cnt);
      end
    end
  end

  // Reference: walk the list in the memory image
  function automatic exp_t model(input int k);
    exp_t e;
    logic [7:0] a, link;
    int s, n;
    a = 8'd0; s = 0; n = 0;
    forever begin
      s += int'(mem[a]);
      n++;
      link = mem[a + 8'd1];
      if (link == 8'd0) begin e.is_err = 1'b0; break; end
      if (n >= 8)       begin e.is_err = 1'b1; break; end
      a = link;
    end
    e.cyc = k + 2*n + 2;
    e.sum = s;
    e.cnt = n;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(output int k);
    start = 1'b1;
    k = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d traversal(s) never completed", q.size());
      q.delete();
    end
    tick();
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    check({name, "_ctrl"}, int'({SUM_SEL, NEXT_SEL, A_SEL, LD_SUM, LD_NEXT, busy, done, err}), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  task automatic load_list3();
    clear_mem();
    mem[0] = 8'd5; mem[1] = 8'd4; mem[4] = 8'd7; mem[5] = 8'd8; mem[8] = 8'd3; mem[9] = 8'd0;
  endtask

  initial begin
    int k, d, n;
    exp_t e;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clear_mem();
    repeat (3) tick();
    start = 1'b1; abort = 1'b1;
    check_quiet("reset_hold");
    check("reset_count", int'(node_count), 0);
    tick();
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    tick();
    check_quiet("idle_after_reset");
    tick();

    // Three-node list, with a stray start mid-traversal
    load_list3();
    start_run(k);
    q.push_back('{1'b0, k + 8, 15, 3});
    while (cyc < k + 4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain();
    repeat (3) tick();

    // Single node list
    clear_mem();
    mem[0] = 8'd9; mem[1] = 8'd0;
    start_run(k);
    q.push_back('{1'b0, k + 4, 9, 1});
    wait_drain();

    // Self-loop hits the node limit
    clear_mem();
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd1; mem[3] = 8'd2;
    start_run(k);
    q.push_back('{1'b1, k + 18, 8, 8});
    wait_drain();

    // Abort in the second ADD, then a clean rerun
    load_list3();
    start_run(k);
    while (cyc < k + 4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(node_count), 2);
    repeat (12) tick();
    check("abort_count_hold", int'(node_count), 2);
    start_run(k);
    q.push_back('{1'b0, k + 8, 15, 3});
    wait_drain();

    // Reset while in LINK
    start_run(k);
    q.push_back('{1'b0, k + 8, 15, 3});
    while (cyc < k + 3) tick();
    @(negedge clk);
    check("in_link", int'({A_SEL, NEXT_SEL, LD_NEXT, LD_SUM}), 4'b1110);
    tick();
    rst = 1'b1;
    q.delete();
    tick();
    check_quiet("reset_in_link");
    check("reset_in_link_count", int'(node_count), 0);
    tick();
    rst = 1'b0;
    repeat (12) tick();

    // Randomized lists, some aborted mid-walk
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      start_run(k);
      e = model(k);
      if ($urandom_range(0, 3) == 0) begin
        n = e.cnt;
        d = $urandom_range(2, 2*n + 1);
        while (cyc < k + d) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("rand_abort_busy", int'(busy), 0);
        check("rand_abort_count", int'(node_count), d / 2);
        repeat (4) tick();
      end else begin
        q.push_back(e);
        wait_drain();
      end
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
